// File: rtl/move_scheduler.sv
// Turns the keyboard report's key slots into one W/A/S/D movement command per frame.
// With MOVE_REPEAT_DELAY_EN defined, a pause of REPEAT_DELAY frames separates the first step from auto-repeat.
module move_scheduler #(
  parameter int unsigned NUM_SLOTS    = 4,
  parameter logic [7:0]  KEY_W        = 8'h1A,
  parameter logic [7:0]  KEY_A        = 8'h04,
  parameter logic [7:0]  KEY_S        = 8'h16,
  parameter logic [7:0]  KEY_D        = 8'h07
`ifdef MOVE_REPEAT_DELAY_EN
  ,
  parameter int unsigned REPEAT_DELAY = 15
`endif
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic [8*NUM_SLOTS-1:0] keycodes,
  output logic [7:0]             move_keycode,
  output logic                   frame_tick,
  output logic [1:0]             active_dir
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_REPEAT, S_DELAY} state_t;

  // Direction index doubles as the held-vector bit: 0=W, 1=A, 2=S, 3=D.
  function automatic logic [1:0] pick_dir(input logic [3:0] v);
    if (v[0])      pick_dir = 2'd0;
    else if (v[2]) pick_dir = 2'd2;
    else if (v[1]) pick_dir = 2'd1;
    else           pick_dir = 2'd3;
  endfunction

  function automatic logic [7:0] key_of(input logic [1:0] dir);
    case (dir)
      2'd0:    key_of = KEY_W;
      2'd1:    key_of = KEY_A;
      2'd2:    key_of = KEY_S;
      default: key_of = KEY_D;
    endcase
  endfunction

  logic       fc_meta_q, fc_sync_q, fc_prev_q, tick_q;
  logic [3:0] held, held_q, newpress;
  logic [1:0] winner_q, winner_d;
  logic       winner_vld_q, winner_vld_d;
  state_t     state_q, state_d;
  logic [7:0] move_q, move_d;
  logic [1:0] dir_q, dir_d;
`ifdef MOVE_REPEAT_DELAY_EN
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_next;
  assign cnt_next = cnt_q + 8'd1;
`endif

  always_comb begin
    held = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (keycodes[8*i +: 8] == KEY_W) held[0] = 1'b1;
      if (keycodes[8*i +: 8] == KEY_A) held[1] = 1'b1;
      if (keycodes[8*i +: 8] == KEY_S) held[2] = 1'b1;
      if (keycodes[8*i +: 8] == KEY_D) held[3] = 1'b1;
    end
  end

  assign newpress = held & ~held_q;

  always_comb begin
    winner_d     = winner_q;
    winner_vld_d = winner_vld_q;
    if (|newpress) begin
      winner_d     = pick_dir(newpress);
      winner_vld_d = 1'b1;
    end else if (!winner_vld_q || !held[winner_q]) begin
      // Winner released: fall back to the highest-priority key still down.
      winner_vld_d = |held;
      if (|held) winner_d = pick_dir(held);
    end
  end

  always_comb begin
    state_d = state_q;
    move_d  = move_q;
    dir_d   = dir_q;
`ifdef MOVE_REPEAT_DELAY_EN
    cnt_d   = cnt_q;
`endif
    if (tick_q) begin
      if (!winner_vld_q) begin
        state_d = S_IDLE;
        move_d  = 8'h00;
      end else begin
        dir_d  = winner_q;
        move_d = key_of(winner_q);
        case (state_q)
          S_IDLE:   state_d = S_STEP;
`ifdef MOVE_REPEAT_DELAY_EN
          S_STEP: begin
            state_d = S_DELAY;
            move_d  = 8'h00;
            cnt_d   = 8'h00;
          end
          S_DELAY: begin
            // dir_q still holds the direction seen at the previous tick.
            if (winner_q != dir_q) begin
              state_d = S_STEP;
            end else if (cnt_next >= 8'(REPEAT_DELAY)) begin
              state_d = S_REPEAT;
            end else begin
              cnt_d  = cnt_next;
              move_d = 8'h00;
            end
          end
`else
          S_STEP:   state_d = S_REPEAT;
`endif
          S_REPEAT: state_d = S_REPEAT;
          default:  state_d = S_IDLE;
        endcase
      end
    end
  end

  // NOTE: every register below is updated with <= so all of them see the same pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fc_meta_q    <= 1'b0;
      fc_sync_q    <= 1'b0;
      fc_prev_q    <= 1'b0;
      tick_q       <= 1'b0;
      held_q       <= '0;
      winner_q     <= 2'd0;
      winner_vld_q <= 1'b0;
      state_q      <= S_IDLE;
      move_q       <= 8'h00;
      dir_q        <= 2'd0;
`ifdef MOVE_REPEAT_DELAY_EN
      cnt_q        <= 8'h00;
`endif
    end else begin
      fc_meta_q    <= frame_clk;
      fc_sync_q    <= fc_meta_q;
      fc_prev_q    <= fc_sync_q;
      tick_q       <= fc_sync_q & ~fc_prev_q;
      held_q       <= held;
      winner_q     <= winner_d;
      winner_vld_q <= winner_vld_d;
      state_q      <= state_d;
      move_q       <= move_d;
      dir_q        <= dir_d;
`ifdef MOVE_REPEAT_DELAY_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign move_keycode = move_q;
  assign frame_tick   = tick_q;
  assign active_dir   = dir_q;

endmodule
